// File: rtl/mem_access_unit.sv
// Memory-stage access controller: byte/half/word loads with extension, sub-word
// stores as read-modify-write, fault classification and one result per operation.
module mem_access_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_readdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_fault
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    logic [1:0]  req_offset;
    logic [1:0]  req_size;
    logic [15:0] req_wdata;
    logic        req_unsigned;
    logic        req_regwrite;
    logic        req_store;
    logic [4:0]  req_rd;

    logic accept;
    logic is_mem;
    logic fault;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;

    always_comb begin
        is_mem = ex_memread | ex_memwrite;
        fault  = is_mem & ((ex_memread & ex_memwrite)
                         | (ex_size == 2'b11)
                         | ((ex_size == 2'b01) & ex_addr[0])
                         | ((ex_size == 2'b10) & (ex_addr[1:0] != 2'b00))
                         | (ex_addr[31:2] >= WORD_LIMIT));
    end

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] result;
        result = word;
        if (size == 2'b00)
            result[{off, 3'b000} +: 8] = wdata[7:0];
        else
            result[{off[1], 4'b0000} +: 16] = wdata;
        return result;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_offset    <= '0;
            req_size      <= '0;
            req_wdata     <= '0;
            req_unsigned  <= 1'b0;
            req_regwrite  <= 1'b0;
            req_store     <= 1'b0;
            req_rd        <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_fault      <= 1'b0;
        end else begin
            // NOTE: wb_valid defaults low every cycle so each completion is a single-cycle pulse.
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_offset   <= ex_addr[1:0];
                        req_size     <= ex_size;
                        req_wdata    <= ex_wdata[15:0];
                        req_unsigned <= ex_unsigned;
                        req_regwrite <= ex_regwrite;
                        req_store    <= ex_memwrite;
                        req_rd       <= ex_rd;
                        if (!is_mem || fault) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= ex_regwrite & ~fault;
                            wb_rd       <= ex_rd;
                            wb_data     <= fault ? 32'h0 : ex_addr;
                            wb_fault    <= fault;
                        end else if (ex_memwrite && ex_size == 2'b10) begin
                            state         <= WR;
                            mem_write     <= 1'b1;
                            mem_address   <= {ex_addr[31:2], 2'b00};
                            mem_writedata <= ex_wdata;
                        end else begin
                            state       <= RD;
                            mem_read    <= 1'b1;
                            mem_address <= {ex_addr[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (req_store) begin
                        // mem_writedata doubles as the merge register for read-modify-write.
                        state         <= WR;
                        mem_write     <= 1'b1;
                        mem_writedata <= merge_lane(mem_readdata, req_wdata, req_size, req_offset);
                    end else begin
                        state       <= IDLE;
                        mem_address <= '0;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= req_regwrite;
                        wb_rd       <= req_rd;
                        wb_data     <= load_extend(mem_readdata, req_size, req_unsigned, req_offset);
                        wb_fault    <= 1'b0;
                    end
                end
                WR: begin
                    state         <= IDLE;
                    mem_write     <= 1'b0;
                    mem_address   <= '0;
                    mem_writedata <= '0;
                    wb_valid      <= 1'b1;
                    wb_regwrite   <= 1'b0;
                    wb_rd         <= req_rd;
                    wb_data       <= '0;
                    wb_fault      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the word-addressed data memory. Accepts one memory or pass-through operation at a time, performs byte/half/word loads with sign or zero extension, and implements sub-word stores as read-modify-write. Flags misaligned and out-of-range accesses, back-pressures EX/MEM while busy, and presents one registered result per operation to the MEM/WB register.

## Interface
- MEM_WORDS, 256: data memory depth in 32-bit words; valid word index range 0..MEM_WORDS-1.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds an operation
- ex_ready  out  1  unit can accept; high only in IDLE
- ex_memread  in  1  load operation
- ex_memwrite  in  1  store operation
- ex_size  in  2  00 byte, 01 half, 10 word; 11 illegal for memory ops
- ex_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- ex_addr  in  32  byte address (ALU result for non-memory ops)
- ex_wdata  in  32  store data; sub-word stores use low bits
- ex_regwrite  in  1  operation writes a register
- ex_rd  in  5  destination register
- mem_address  out  32  word-aligned byte address to data memory
- mem_writedata  out  32  full word to data memory
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- mem_readdata  in  32  word returned by data memory
- wb_valid  out  1  one-cycle pulse per completed operation
- wb_regwrite  out  1  result writes register (forced 0 on fault)
- wb_rd  out  5  destination register
- wb_data  out  32  load result, or ex_addr for non-memory ops
- wb_fault  out  1  misaligned/illegal/out-of-range, valid with wb_valid

## Operation
- States: IDLE, RD, WR. Accept = ex_valid & ex_ready; request fields latched into internal registers on accept.
- Classification at accept: non-memory (memread=0, memwrite=0); fault if memread&memwrite, size=11 on a memory op, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
- Non-memory or fault: IDLE->IDLE; wb registers loaded at accept edge; fault sets wb_fault=1, wb_regwrite=0, wb_data=0, no memory access.
- Load: IDLE->RD; in RD mem_read=1; readdata sampled at RD's closing edge, lane extracted and extended into wb_data; RD->IDLE.
- Word store: IDLE->WR; in WR mem_write=1, mem_writedata=req wdata; WR->IDLE; wb_regwrite=0.
- Sub-word store: IDLE->RD (mem_read=1, word captured into merge register) ->WR (mem_write=1, merged word) ->IDLE.
- Lanes little-endian: byte k=addr[1:0] at bits 8k+7:8k; half h=addr[1] at bits 16h+15:16h. Stores replace only that lane with wdata[7:0] or wdata[15:0]; other lanes keep read values.
- mem_address = {req_addr[31:2],2'b00} whenever mem_read or mem_write high; 0 in IDLE.

## Timing
- Reset: state IDLE, ex_ready=1, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, all wb_* = 0, internal registers cleared.
- Latency accept->wb_valid: non-memory/fault 1 cycle; load 2; word store 2; sub-word store 3.
- ex_ready combinational from state; EX/MEM must hold fields stable while ex_ready=0. Back-to-back accepts allowed in IDLE every cycle for non-memory ops.
- wb_valid high exactly one cycle; wb_regwrite/rd/data/fault hold last values until next completion.
- mem_read, mem_write never high simultaneously; each high exactly one cycle per access.
- mem_readdata must be valid by the rising edge ending the RD cycle.
- Reset asserted mid-operation: outputs drop immediately; pending store aborted, no write occurs unless WR's closing edge preceded reset; no wb_valid for aborted op.

## Test plan
- Reset then non-memory op addr=0x1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=0x00001234, wb_rd=5, ex_ready stays 1.
- sw 0x80FF7F01 to 0x20 -> one WR cycle, mem_address=0x20, mem_writedata=0x80FF7F01; then lw 0x20 -> wb_data=0x80FF7F01 after 2 cycles.
- After above: lb 0x20->0x00000001, lb 0x21->0x0000007F, lb 0x22->0xFFFFFFFF, lbu 0x22->0x000000FF, lh 0x22->0xFFFF80FF, lhu 0x22->0x000080FF.
- sb 0xAB to 0x23 -> RD then WR with mem_writedata=0xABFF7F01, ex_ready low 2 cycles; sh 0x1234 to 0x20 -> word 0xABFF1234.
- lw 0x22, lh 0x21, memread&memwrite, addr=MEM_WORDS*4 -> each: wb_fault=1, wb_regwrite=0, mem_read/mem_write never asserted.
- Assert reset during WR of sb to 0x24 -> mem_write drops at once, word at 0x24 unchanged, no wb_valid, ex_ready=1 after release.
